// File: rtl/soduku_solver_ctrl.sv
// ---------------------------------------------------------------------------
// soduku_solver_ctrl
// Sequences one sudoku solve: streams 81 BCD cells into a board register,
// holds an external solver in reset, lets it run until every cell is filled
// or a cycle limit expires, then streams the 81 result cells back out.
//
// Ports
//   clk_in, reset_in          single clock, synchronous active-high reset
//   cell_valid_in/_data_in    load stream in (row-major, 0 = blank)
//   cell_ready_out            load stream ready (IDLE and DONE)
//   start_in                  begin solving the loaded board (LOADED only)
//   solver_reset_out          solver reset, low only while solving
//   solver_board_out          board register to the solver, cell 0 in MSBs
//   solver_board_in           solver board, sampled for the result
//   res_valid_out/_data_out   result stream out (DRAIN)
//   res_ready_in              result stream ready from the sink
//   busy_out, done_out        status flags
//   timeout_out               last solve ended on the cycle limit
// ---------------------------------------------------------------------------
module soduku_solver_ctrl #(
   parameter int GRID_SIZE      = 9,
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic         clk_in,
   input  logic         reset_in,
   input  logic         cell_valid_in,
   input  logic [3:0]   cell_data_in,
   output logic         cell_ready_out,
   input  logic         start_in,
   output logic         solver_reset_out,
   output logic [323:0] solver_board_out,
   input  logic [323:0] solver_board_in,
   output logic         res_valid_out,
   output logic [3:0]   res_data_out,
   input  logic         res_ready_in,
   output logic         busy_out,
   output logic         done_out,
   output logic         timeout_out
);

   localparam int         LAST_CELL = GRID_SIZE * GRID_SIZE - 1;
   localparam logic [6:0] LAST_IDX  = 7'(LAST_CELL);
   localparam int         CNT_MAX   = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
   localparam int         CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, LOADED, SOLVER_RST, SOLVE, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [6:0]             idx, idx_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   timeout_q, timeout_nxt;
   logic [LAST_CELL:0][3:0] board;
   logic [LAST_CELL:0][3:0] result;
   logic [LAST_CELL:0][3:0] solver_view;
   logic                   load_hs;
   logic                   capture;
   logic                   solved;

   // Non-BCD codes are treated as blanks so the solver never sees them.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > 4'd9) ? 4'd0 : v;
   endfunction

   // Element LAST_CELL of the packed array sits in the MSBs, so cell k
   // lives at element LAST_CELL-k.
   assign solver_view      = solver_board_in;
   assign solver_board_out = board;
   assign timeout_out      = timeout_q;

   always_comb begin
      solved = 1'b1;
      for (int i = 0; i <= LAST_CELL; i++) begin
         if (solver_view[i] == 4'd0) solved = 1'b0;
      end
   end

   always_comb begin
      state_nxt        = state;
      idx_nxt          = idx;
      cnt_nxt          = cnt;
      timeout_nxt      = timeout_q;
      load_hs          = 1'b0;
      capture          = 1'b0;
      cell_ready_out   = 1'b0;
      solver_reset_out = 1'b1;
      res_valid_out    = 1'b0;
      res_data_out     = 4'd0;
      busy_out         = 1'b0;
      done_out         = 1'b0;
      case (state)
         IDLE: begin
            cell_ready_out = 1'b1;
            load_hs        = cell_valid_in;
            if (load_hs) begin
               if (idx == LAST_IDX) begin
                  idx_nxt   = 7'd0;
                  state_nxt = LOADED;
               end else begin
                  idx_nxt = idx + 7'd1;
               end
            end
         end
         LOADED: begin
            if (start_in) begin
               cnt_nxt   = '0;
               state_nxt = SOLVER_RST;
            end
         end
         SOLVER_RST: begin
            busy_out = 1'b1;
            if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
               cnt_nxt   = '0;
               state_nxt = SOLVE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SOLVE: begin
            busy_out         = 1'b1;
            solver_reset_out = 1'b0;
            cnt_nxt          = cnt + 1'b1;
            // A board that completes on the last allowed cycle still counts
            // as solved.
            if (solved) begin
               capture     = 1'b1;
               timeout_nxt = 1'b0;
               state_nxt   = DRAIN;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               capture     = 1'b1;
               timeout_nxt = 1'b1;
               state_nxt   = DRAIN;
            end
         end
         DRAIN: begin
            busy_out      = 1'b1;
            res_valid_out = 1'b1;
            res_data_out  = result[LAST_IDX - idx];
            if (res_ready_in) begin
               if (idx == LAST_IDX) begin
                  idx_nxt   = 7'd0;
                  state_nxt = DONE;
               end else begin
                  idx_nxt = idx + 7'd1;
               end
            end
         end
         DONE: begin
            done_out       = 1'b1;
            cell_ready_out = 1'b1;
            load_hs        = cell_valid_in;
            // idx is 0 here, so the first new cell lands in cell 0.
            if (load_hs) begin
               timeout_nxt = 1'b0;
               idx_nxt     = 7'd1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         idx       <= 7'd0;
         cnt       <= '0;
         timeout_q <= 1'b0;
         board     <= '0;
         result    <= '0;
      end else begin
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
         if (load_hs) board[LAST_IDX - idx] <= bcd_clamp(cell_data_in);
         if (capture) result <= solver_view;
      end
   end

endmodule

// File: tb/tb_soduku_solver_ctrl.sv
module tb_soduku_solver_ctrl;

   localparam int T_CYC = 16;

   logic         clk_in = 1'b0;
   logic         reset_in = 1'b1;
   logic         cell_valid_in = 1'b0;
   logic [3:0]   cell_data_in = 4'd0;
   logic         cell_ready_out;
   logic         start_in = 1'b0;
   logic         solver_reset_out;
   logic [323:0] solver_board_out;
   logic [323:0] solver_board_in;
   logic         res_valid_out;
   logic [3:0]   res_data_out;
   logic         res_ready_in = 1'b0;
   logic         busy_out;
   logic         done_out;
   logic         timeout_out;

   soduku_solver_ctrl #(.GRID_SIZE(9), .RESET_CYCLES(2), .TIMEOUT_CYCLES(T_CYC)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .cell_valid_in(cell_valid_in), .cell_data_in(cell_data_in), .cell_ready_out(cell_ready_out),
      .start_in(start_in), .solver_reset_out(solver_reset_out),
      .solver_board_out(solver_board_out), .solver_board_in(solver_board_in),
      .res_valid_out(res_valid_out), .res_data_out(res_data_out), .res_ready_in(res_ready_in),
      .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out)
   );

   always #5 clk_in = ~clk_in;

   int n_pass = 0;
   int n_total = 0;

   // Reference complete board: every cell non-zero.
   int ref_sol[81] = '{2,5,4,8,1,3,6,9,7,
                       8,1,3,6,9,7,2,5,4,
                       6,9,7,2,5,4,8,1,3,
                       5,4,8,1,3,6,9,7,2,
                       1,3,6,9,7,2,5,4,8,
                       9,7,2,5,4,8,1,3,6,
                       4,8,1,3,6,9,7,2,5,
                       3,6,9,7,2,5,4,8,1,
                       9,4,6,3,5,7,2,1,8};
   int load_vals[81];
   int model_board[81];

   // Behavioural stand-in for the solver: loads the board while held in
   // reset, then fills every blank from ref_sol so the fill is visible in
   // solve cycle sol_lat (never, if sol_lat is beyond the limit).
   int           sol_lat = 0;
   int           sol_cnt = 0;
   logic [323:0] sol_board = '0;
   assign solver_board_in = sol_board;

   function automatic logic [323:0] fill(input logic [323:0] b);
      logic [323:0] v;
      v = b;
      for (int k = 0; k < 81; k++)
         if (v[323-4*k -: 4] == 4'd0) v[323-4*k -: 4] = 4'(ref_sol[k]);
      return v;
   endfunction

   function automatic logic [323:0] pack_model();
      logic [323:0] v;
      for (int k = 0; k < 81; k++) v[323-4*k -: 4] = 4'(model_board[k]);
      return v;
   endfunction

   always @(posedge clk_in) begin
      if (solver_reset_out) begin
         sol_cnt   <= 0;
         sol_board <= solver_board_out;
      end else begin
         sol_cnt <= sol_cnt + 1;
         if (sol_cnt == sol_lat - 1) sol_board <= fill(sol_board);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk_board(input string name, input logic [323:0] act, input logic [323:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, cell_ready_out, 1);
      chk({tag, "_srst"}, solver_reset_out, 1);
      chk({tag, "_rvalid"}, res_valid_out, 0);
      chk({tag, "_rdata"}, res_data_out, 0);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_timeout"}, timeout_out, 0);
      chk_board({tag, "_board"}, solver_board_out, '0);
   endtask

   task automatic load_board(input bit start_mid, input bit from_done);
      for (int k = 0; k < 81; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            cell_valid_in = 1'b0;
            tick();
         end
         if (start_mid && k == 40) begin
            cell_valid_in = 1'b0;
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
            chk("start_ignored_ready", cell_ready_out, 1);
            chk("start_ignored_busy", busy_out, 0);
            chk("start_ignored_srst", solver_reset_out, 1);
         end
         cell_valid_in = 1'b1;
         cell_data_in  = 4'(load_vals[k]);
         tick();
         cell_valid_in = 1'b0;
         model_board[k] = (load_vals[k] > 9) ? 0 : load_vals[k];
         if (from_done && k == 0) begin
            chk("reload_done_cleared", done_out, 0);
            chk("reload_timeout_cleared", timeout_out, 0);
            chk("reload_ready", cell_ready_out, 1);
         end
      end
      tick();
      chk("loaded_ready", cell_ready_out, 0);
      chk("loaded_busy", busy_out, 0);
      chk_board("loaded_board", solver_board_out, pack_model());
   endtask

   task automatic solve_and_drain(input string tag);
      bit           complete;
      int           solved_at, dur, n, hs, cyc;
      bit           exp_to, stalled;
      logic [3:0]   last;
      logic [323:0] exp_res;
      complete = 1'b1;
      for (int k = 0; k < 81; k++) if (model_board[k] == 0) complete = 1'b0;
      solved_at = complete ? 0 : sol_lat;
      if (solved_at <= T_CYC - 1) begin
         dur = solved_at + 1; exp_to = 1'b0; exp_res = fill(pack_model());
      end else begin
         dur = T_CYC; exp_to = 1'b1; exp_res = pack_model();
      end

      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = 0;
      while (busy_out && solver_reset_out && !res_valid_out && n < 100) begin
         n++;
         tick();
      end
      chk({tag, "_rst_cycles"}, n, 2);
      n = 0;
      while (!solver_reset_out && n < 1000) begin
         n++;
         if (n == 1) chk({tag, "_solve_busy"}, busy_out, 1);
         tick();
      end
      chk({tag, "_solve_cycles"}, n, dur);
      chk({tag, "_drain_valid"}, res_valid_out, 1);
      chk({tag, "_drain_timeout"}, timeout_out, exp_to);

      hs = 0; cyc = 0; stalled = 1'b0; last = 4'd0;
      while (hs < 81 && cyc < 2000) begin
         if (stalled) chk({tag, "_stall_stable"}, res_data_out, last);
         res_ready_in = 1'($urandom_range(0, 1));
         if (res_valid_out && res_ready_in) begin
            chk({tag, "_res_cell"}, res_data_out, exp_res[323-4*hs -: 4]);
            hs++;
            stalled = 1'b0;
         end else begin
            stalled = res_valid_out;
            last    = res_data_out;
         end
         cyc++;
         tick();
      end
      res_ready_in = 1'b0;
      chk({tag, "_handshakes"}, hs, 81);
      chk({tag, "_done"}, done_out, 1);
      chk({tag, "_done_rvalid"}, res_valid_out, 0);
      chk({tag, "_done_busy"}, busy_out, 0);
      chk({tag, "_done_ready"}, cell_ready_out, 1);
      chk({tag, "_done_timeout"}, timeout_out, exp_to);
   endtask

   typedef struct {
      logic       valid;
      logic [3:0] data;
      logic       start;
      logic       exp_ready;
      logic       exp_busy;
      int         nib;
      logic [3:0] exp_nib;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [323:0] tmp;
      int n;

      vecs[0] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 0, 4'd0};
      vecs[1] = '{1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 0, 4'd7};
      vecs[2] = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 1, 4'd0};
      vecs[3] = '{1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 2, 4'd9};
      vecs[4] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 3, 4'd0};
      vecs[5] = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 4, 4'd3};
      vecs[6] = '{1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 0, 4'd7};

      tick();
      reset_in = 1'b0;
      check_reset_state("reset");

      for (int i = 0; i < 7; i++) begin
         cell_valid_in = vecs[i].valid;
         cell_data_in  = vecs[i].data;
         start_in      = vecs[i].start;
         tick();
         tmp = solver_board_out;
         chk("vec_ready", cell_ready_out, vecs[i].exp_ready);
         chk("vec_busy", busy_out, vecs[i].exp_busy);
         chk("vec_nibble", tmp[323-4*vecs[i].nib -: 4], vecs[i].exp_nib);
      end
      cell_valid_in = 1'b0;
      start_in = 1'b0;
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;

      // Complete board, start pulsed mid-load, random sink stalls.
      for (int k = 0; k < 81; k++) load_vals[k] = ref_sol[k];
      sol_lat = 0;
      load_board(1'b1, 1'b0);
      solve_and_drain("complete");

      // Cell 0 blank, reloaded from DONE.
      load_vals[0] = 0;
      sol_lat = 3;
      load_board(1'b0, 1'b1);
      solve_and_drain("blank0");

      // All-zero board never solves: timeout after 16 cycles.
      for (int k = 0; k < 81; k++) load_vals[k] = 0;
      sol_lat = 1000;
      load_board(1'b0, 1'b1);
      solve_and_drain("timeout");

      // Solved on the final allowed cycle beats the timeout.
      for (int k = 0; k < 81; k++) load_vals[k] = ref_sol[k];
      load_vals[80] = 0;
      sol_lat = T_CYC - 1;
      load_board(1'b0, 1'b1);
      solve_and_drain("priority");

      // Random mix of values, blanks and non-BCD codes.
      for (int k = 0; k < 81; k++) begin
         n = int'($urandom_range(0, 9));
         if (n < 6)      load_vals[k] = ref_sol[k];
         else if (n < 8) load_vals[k] = 0;
         else            load_vals[k] = int'($urandom_range(10, 15));
      end
      sol_lat = int'($urandom_range(1, 14));
      load_board(1'b0, 1'b1);
      solve_and_drain("random");

      // Reset in the middle of SOLVE.
      for (int k = 0; k < 81; k++) load_vals[k] = ref_sol[k];
      load_vals[0] = 0;
      sol_lat = 1000;
      load_board(1'b0, 1'b1);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = 0;
      while (solver_reset_out && n < 50) begin
         n++;
         tick();
      end
      chk("midsolve_reached", solver_reset_out, 0);
      tick();
      tick();
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      check_reset_state("midsolve");

      // Reset in the middle of DRAIN, then confirm loading restarts at cell 0.
      load_vals[0] = ref_sol[0];
      sol_lat = 0;
      load_board(1'b0, 1'b0);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = 0;
      while (!res_valid_out && n < 50) begin
         n++;
         tick();
      end
      chk("middrain_reached", res_valid_out, 1);
      res_ready_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      res_ready_in = 1'b0;
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      check_reset_state("middrain");
      cell_valid_in = 1'b1;
      cell_data_in  = 4'd6;
      tick();
      cell_valid_in = 1'b0;
      tmp = solver_board_out;
      chk("postreset_cell0", tmp[323 -: 4], 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
